// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types for the command master: response codes, FSM states
// and the strobe-width helper.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } axil_mst_state_t;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a register slave.
interface axil_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );

endinterface

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator turning single-beat register commands into bus transactions.
// Optional watchdog enabled by defining AXIL_MST_TIMEOUT_EN.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [ADDR_WIDTH-1:0]             cmd_addr,
    input  logic [DATA_WIDTH-1:0]             cmd_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0] cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output resp_t                             rsp_resp,
    output logic                              rsp_timeout,
    axil_cmd_master_if.master                 axi
);

    localparam int STRB_W = strb_width(DATA_WIDTH);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("axil_cmd_master: DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axil_cmd_master: TIMEOUT_CYCLES must be at least 2");
    end

    axil_mst_state_t       state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                  aw_done_q, w_done_q, aw_done_d, w_done_d;
    logic                  cmd_ready_q, rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    resp_t                 rsp_resp_q;

    // AW and W complete independently; the _d view includes this cycle's handshake.
    always_comb begin
        aw_done_d = aw_done_q | (awvalid_q & axi.AWREADY);
        w_done_d  = w_done_q  | (wvalid_q  & axi.WREADY);
    end

`ifdef AXIL_MST_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             rsp_timeout_q;
    logic             busy, timeout_hit;

    assign busy        = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                         (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
    assign timeout_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
`ifdef AXIL_MST_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
`ifdef AXIL_MST_TIMEOUT_EN
            // Watchdog abandons the bus transaction and reports DECERR to the requester.
            if (busy && timeout_hit) begin
                awvalid_q     <= 1'b0;
                wvalid_q      <= 1'b0;
                arvalid_q     <= 1'b0;
                bready_q      <= 1'b0;
                rready_q      <= 1'b0;
                rsp_rdata_q   <= '0;
                rsp_resp_q    <= DECERR;
                rsp_timeout_q <= 1'b1;
                rsp_valid_q   <= 1'b1;
                tmo_cnt_q     <= '0;
                state_q       <= ST_RSP;
            end else begin
                tmo_cnt_q <= busy ? tmo_cnt_q + CNT_W'(1) : '0;
`else
            begin
`endif
                case (state_q)
                    ST_IDLE: begin
                        cmd_ready_q <= 1'b1;
                        if (cmd_valid && cmd_ready_q) begin
                            cmd_ready_q <= 1'b0;
                            addr_q      <= cmd_addr;
                            wdata_q     <= cmd_wdata;
                            wstrb_q     <= cmd_wstrb;
                            aw_done_q   <= 1'b0;
                            w_done_q    <= 1'b0;
`ifdef AXIL_MST_TIMEOUT_EN
                            rsp_timeout_q <= 1'b0;
`endif
                            if (cmd_write) begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                state_q   <= ST_WR_REQ;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= ST_RD_REQ;
                            end
                        end
                    end
                    ST_WR_REQ: begin
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                        if (awvalid_q && axi.AWREADY) awvalid_q <= 1'b0;
                        if (wvalid_q && axi.WREADY)   wvalid_q  <= 1'b0;
                        if (aw_done_d && w_done_d) begin
                            bready_q <= 1'b1;
                            state_q  <= ST_WR_RESP;
`ifdef AXIL_MST_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end
                    end
                    ST_WR_RESP: begin
                        if (axi.BVALID && bready_q) begin
                            bready_q    <= 1'b0;
                            rsp_rdata_q <= '0;
                            rsp_resp_q  <= resp_t'(axi.BRESP);
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RSP;
                        end
                    end
                    ST_RD_REQ: begin
                        if (arvalid_q && axi.ARREADY) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            state_q   <= ST_RD_DATA;
`ifdef AXIL_MST_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end
                    end
                    ST_RD_DATA: begin
                        if (axi.RVALID && rready_q) begin
                            rready_q    <= 1'b0;
                            rsp_rdata_q <= axi.RDATA;
                            rsp_resp_q  <= resp_t'(axi.RRESP);
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RSP;
                        end
                    end
                    ST_RSP: begin
                        if (rsp_ready) begin
                            rsp_valid_q <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign axi.AWADDR  = addr_q;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready_q;
    assign axi.ARADDR  = addr_q;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed scoreboard bench for axil_cmd_master with a configurable AXI-Lite slave model.
// Define AXIL_MST_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=16.
module tb_axil_cmd_master;
    import axil_pkg::*;

`ifdef AXIL_MST_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } exp_t;

    logic        clk, ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    resp_t       rsp_resp;

    axil_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axil_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .ACLK(clk), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .axi(axi)
    );

    int   checks = 0;
    int   fails  = 0;
    exp_t sbQueue[$];

    int          awDelay = 0, wDelay = 0, arDelay = 0, rspDelay = 0;
    logic        bEnable = 1'b1;
    logic [1:0]  slaveBresp = 2'b00, slaveRresp = 2'b00;
    logic [31:0] slaveRdata = '0;
    int          awCnt = 0, wCnt = 0, arCnt = 0, rspCnt = 0, bHsCount = 0;
    logic        awGot = 0, wGot = 0, arGot = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave handshake bookkeeping, sampled at the active edge before DUT updates land.
    always @(posedge clk) begin
        if (!ARESETn) begin
            awGot = 0; wGot = 0; arGot = 0;
        end else begin
            if (axi.AWVALID && axi.AWREADY) awGot = 1;
            if (axi.WVALID && axi.WREADY)   wGot  = 1;
            if (axi.BVALID && axi.BREADY) begin
                awGot = 0; wGot = 0; bHsCount++;
            end
            if (axi.ARVALID && axi.ARREADY) arGot = 1;
            if (axi.RVALID && axi.RREADY)   arGot = 0;
        end
    end

    // Slave outputs change on the falling edge, with per-channel READY delays.
    always @(negedge clk) begin
        if (axi.AWVALID) begin axi.AWREADY = (awCnt >= awDelay); awCnt++; end
        else begin axi.AWREADY = 0; awCnt = 0; end
        if (axi.WVALID) begin axi.WREADY = (wCnt >= wDelay); wCnt++; end
        else begin axi.WREADY = 0; wCnt = 0; end
        if (axi.ARVALID) begin axi.ARREADY = (arCnt >= arDelay); arCnt++; end
        else begin axi.ARREADY = 0; arCnt = 0; end
        axi.BVALID = awGot && wGot && bEnable;
        axi.BRESP  = slaveBresp;
        axi.RVALID = arGot;
        axi.RDATA  = slaveRdata;
        axi.RRESP  = slaveRresp;
    end

    // Response monitor: payload must match the queue head every cycle it is presented.
    always @(negedge clk) begin
        exp_t e;
        if (ARESETn && rsp_valid) begin
            checkOutput("cmd_ready_during_rsp", {63'd0, cmd_ready}, 64'd0);
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
                rsp_ready = 1'b1;
            end else begin
                e = sbQueue[0];
                checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                checkOutput("rsp_resp", {62'd0, rsp_resp}, {62'd0, e.resp});
                checkOutput("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, e.tmo});
                if (rspCnt >= rspDelay) begin
                    rsp_ready = 1'b1;
                    void'(sbQueue.pop_front());
                end else begin
                    rsp_ready = 1'b0;
                end
                rspCnt++;
            end
        end else begin
            rsp_ready = 1'b0;
            rspCnt    = 0;
        end
    end

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic expectRsp,
                                 input logic [31:0] expRdata, input logic [1:0] expResp,
                                 input logic expTmo);
        exp_t e;
        logic accepted;
        int   n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        if (expectRsp) begin
            e.rdata = expRdata; e.resp = expResp; e.tmo = expTmo;
            sbQueue.push_back(e);
        end
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 200) begin
            @(posedge clk);
            accepted = cmd_ready;
            n++;
        end
        #1 cmd_valid = 1'b0;
        if (!accepted) checkOutput("cmd_accept_timeout", {63'd0, accepted}, 64'd1);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 300 && (sbQueue.size() != 0 || rsp_valid); i++) @(negedge clk);
        checkOutput("drain", 64'(sbQueue.size()), 64'd0);
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, "_awvalid"}, {63'd0, axi.AWVALID}, 64'd0);
        checkOutput({tag, "_wvalid"},  {63'd0, axi.WVALID}, 64'd0);
        checkOutput({tag, "_arvalid"}, {63'd0, axi.ARVALID}, 64'd0);
        checkOutput({tag, "_bready"},  {63'd0, axi.BREADY}, 64'd0);
        checkOutput({tag, "_rready"},  {63'd0, axi.RREADY}, 64'd0);
        checkOutput({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd0);
        checkOutput({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        checkOutput({tag, "_awaddr"}, {32'd0, axi.AWADDR}, 64'd0);
    endtask

    initial begin
        int n;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0;
        axi.AWREADY = 0; axi.WREADY = 0; axi.ARREADY = 0;
        axi.BVALID = 0; axi.BRESP = '0; axi.RVALID = 0; axi.RDATA = '0; axi.RRESP = '0;
        ARESETn = 1'b1;
        #2 ARESETn = 1'b0;
        #1 checkAllLow("reset");
        repeat (3) @(negedge clk);
        ARESETn = 1'b1;
        checkOutput("cmd_ready_after_release", {63'd0, cmd_ready}, 64'd0);
        @(posedge clk);
        #1 checkOutput("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);

        $display("[TB] Test 1: write, AW/W ready together");
        applyStimulus(1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("t1_awvalid", {63'd0, axi.AWVALID}, 64'd1);
        checkOutput("t1_wvalid", {63'd0, axi.WVALID}, 64'd1);
        checkOutput("t1_awaddr", {32'd0, axi.AWADDR}, 64'h0);
        checkOutput("t1_wdata", {32'd0, axi.WDATA}, 64'hDEADBEEF);
        checkOutput("t1_wstrb", {60'd0, axi.WSTRB}, 64'hF);
        waitIdle();

        $display("[TB] Test 2: write, W accepted 3 cycles before AW");
        awDelay = 3; wDelay = 0; bHsCount = 0;
        applyStimulus(1'b1, 32'h8, 32'h12345678, 4'hF, 1'b1, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t2_wvalid_dropped", {63'd0, axi.WVALID}, 64'd0);
        checkOutput("t2_awvalid_held", {63'd0, axi.AWVALID}, 64'd1);
        checkOutput("t2_awaddr", {32'd0, axi.AWADDR}, 64'h8);
        waitIdle();
        checkOutput("t2_b_count", 64'(bHsCount), 64'd1);
        awDelay = 0;

        $display("[TB] Test 3: read, ARREADY delayed 2 cycles");
        arDelay = 2; slaveRdata = 32'h12345678; slaveRresp = 2'b00;
        applyStimulus(1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h12345678, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("t3_arvalid", {63'd0, axi.ARVALID}, 64'd1);
        checkOutput("t3_araddr", {32'd0, axi.ARADDR}, 64'h8);
        checkOutput("t3_awvalid", {63'd0, axi.AWVALID}, 64'd0);
        waitIdle();
        arDelay = 0;

        $display("[TB] Test 4: SLVERR write with stalled response consumer");
        slaveBresp = 2'b10; rspDelay = 5;
        applyStimulus(1'b1, 32'h4, 32'hA5A5A5A5, 4'h3, 1'b1, 32'h0, 2'b10, 1'b0);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (rsp_valid && n < 100) begin @(negedge clk); n++; end
        checkOutput("t4_stall_cycles", 64'(n), 64'd6);
        checkOutput("t4_cmd_ready_after_rsp", {63'd0, cmd_ready}, 64'd1);
        waitIdle();
        slaveBresp = 2'b00; rspDelay = 0;

        $display("[TB] Test 5: reset while AWVALID high");
        awDelay = 100;
        applyStimulus(1'b1, 32'h10, 32'h55AA55AA, 4'hF, 1'b0, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("t5_awvalid_before", {63'd0, axi.AWVALID}, 64'd1);
        #3 ARESETn = 1'b0;
        #1 checkAllLow("t5_abort");
        repeat (2) @(negedge clk);
        ARESETn = 1'b1;
        awDelay = 0;
        @(posedge clk);
        #1 checkOutput("t5_cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        slaveRdata = 32'hCAFEF00D;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, 2'b00, 1'b0);
        waitIdle();

`ifdef AXIL_MST_TIMEOUT_EN
        $display("[TB] Test 6: watchdog on missing BVALID");
        bEnable = 1'b0;
        applyStimulus(1'b1, 32'h20, 32'h0BADF00D, 4'hF, 1'b1, 32'h0, 2'b11, 1'b1);
        n = 0;
        while (!axi.BREADY && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (axi.BREADY && n < 100) begin @(negedge clk); n++; end
        checkOutput("t6_bready_cycles", 64'(n), 64'd16);
        checkOutput("t6_bready_dropped", {63'd0, axi.BREADY}, 64'd0);
        waitIdle();
        bEnable = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
